pe_conv_rr_arbiter: RTL and testbench

- Shares one mixed-width conversion PE (i16 operand, i32 operand -> i16 result) among N_REQ requesters.
- Round-robin issue of operand pairs into the PE. In-order tag FIFO steers each PE result back to the requester that issued it.
- Includes a drain sequencer, so PE route tables can be reconfigured safely with no operations in flight.
- Sits between requester-side dataflow ports and a pe_conv_top-style PE instance.

---
 rtl/pe_conv_arb_pkg.sv | 24 ++
 rtl/pe_conv_tag_fifo.sv | 71 +++++++
 rtl/pe_conv_rr_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_pe_conv_rr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_conv_arb_pkg.sv
// Shared types and constants for the conversion-PE round-robin arbiter.
//   arb_state_e        : issue/drain sequencer states
//   ERR_*              : error codes latched into error_code
//   clog2()            : tag width for a requester count (minimum 1 bit)
package pe_conv_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    IDLE  = 2'd2
  } arb_state_e;

  localparam logic [15:0] ERR_NONE          = 16'h0000;
  localparam logic [15:0] ERR_ORPHAN_RESULT = 16'h0001;
  localparam logic [15:0] ERR_TAG_OVERFLOW  = 16'h0002;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pe_conv_tag_fifo.sv
// In-order tag FIFO: remembers which requester issued each operation in flight
// so the PE result can be steered back to it.
// Ports:
//   clk, rst_n        clock, async active-low reset (FIFO empties)
//   push, push_tag    write a tag; ignored while full, even if popping
//   pop               drop the head tag; ignored while empty
//   head_tag          tag at the head (valid when !empty)
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH
module pe_conv_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_tag = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even when a pop frees a slot this
  // cycle; the freed slot becomes usable on the next cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pe_conv_rr_arbiter.sv
// Round-robin arbiter sharing one conversion PE (A_W operand, B_W operand ->
// A_W result) among N_REQ requesters, with a drain sequencer so PE routing can
// be reconfigured with nothing in flight.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | issuing; drain_req seen -> DRAIN (no grant that cycle)
// DRAIN | no issue; waits for the tag FIFO to empty -> IDLE
// IDLE  | drain_done = 1; drain_req low -> RUN
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/ready/a/b        per-requester operand pairs (packed slices)
//   pe_in0_*, pe_in1_*         PE operand ports, always presented together
//   pe_out_*                   PE result port
//   rsp_valid/ready, rsp_data  per-requester result handshake, shared data
//   drain_req, drain_done      drain request level / drained status
//   error_valid, error_code    sticky first error
// Optional (PE_CONV_RR_ARBITER_STATS_EN defined):
//   grant_count                per-requester 16-bit wrapping fire counters
//   max_occupancy              tag FIFO high-water mark
module pe_conv_rr_arbiter
  import pe_conv_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int A_W   = 16,
  parameter int B_W   = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  output logic                   pe_in0_valid,
  input  logic                   pe_in0_ready,
  output logic [A_W-1:0]         pe_in0_data,
  output logic                   pe_in1_valid,
  input  logic                   pe_in1_ready,
  output logic [B_W-1:0]         pe_in1_data,
  input  logic                   pe_out_valid,
  output logic                   pe_out_ready,
  input  logic [A_W-1:0]         pe_out_data,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [A_W-1:0]         rsp_data,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic                   error_valid,
  output logic [15:0]            error_code
`ifdef PE_CONV_RR_ARBITER_STATS_EN
  ,
  output logic [N_REQ*16-1:0]    grant_count,
  output logic [$clog2(DEPTH):0] max_occupancy
`endif
);

  localparam int TAG_W = clog2(N_REQ);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_e       state_q, state_d;
  logic [TAG_W-1:0] rr_q, rr_d;
  logic             err_valid_q, err_valid_d;
  logic [15:0]      err_code_q, err_code_d;

  logic [TAG_W-1:0] grant;
  logic             any_req;
  logic             issue_ok;
  logic             fire;
  logic             pop;
  logic             orphan;
  logic             tag_overflow;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = rr_q;
    any_req = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_req && req_valid[idx[TAG_W-1:0]]) begin
        any_req = 1'b1;
        grant   = idx[TAG_W-1:0];
      end
    end
  end

  // drain_req blocks issue in the very cycle it is first seen in RUN.
  assign issue_ok     = (state_q == RUN) && !drain_req && !fifo_full;
  assign pe_in0_valid = issue_ok && any_req;
  assign pe_in1_valid = issue_ok && any_req;
  assign fire         = pe_in0_valid && pe_in1_valid && pe_in0_ready && pe_in1_ready;

  always_comb begin
    pe_in0_data = '0;
    pe_in1_data = '0;
    req_ready   = '0;
    if (pe_in0_valid) begin
      pe_in0_data = req_a[int'(grant)*A_W +: A_W];
      pe_in1_data = req_b[int'(grant)*B_W +: B_W];
    end
    if (fire) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (fire) rr_d = (int'(grant) == N_REQ - 1) ? '0 : grant + TAG_W'(1);
  end

  always_comb begin
    rsp_valid    = '0;
    pe_out_ready = 1'b0;
    rsp_data     = '0;
    if (!fifo_empty) begin
      rsp_valid[head_tag] = pe_out_valid;
      pe_out_ready        = rsp_ready[head_tag];
      if (pe_out_valid) rsp_data = pe_out_data;
    end
  end

  assign pop    = pe_out_valid && pe_out_ready;
  assign orphan = pe_out_valid && fifo_empty;
  // Checked against the raw count rather than fifo_full so a broken full
  // flag still gets caught.
  assign tag_overflow = fire && (fifo_count >= CNT_W'(DEPTH));

  pe_conv_tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fire),
    .push_tag (grant),
    .pop      (pop),
    .head_tag (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = IDLE;
      IDLE:    if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign drain_done = (state_q == IDLE);

  always_comb begin
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    if (!err_valid_q) begin
      if (orphan) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_ORPHAN_RESULT;
      end else if (tag_overflow) begin
        err_valid_d = 1'b1;
        err_code_d  = ERR_TAG_OVERFLOW;
      end
    end
  end

  assign error_valid = err_valid_q;
  assign error_code  = err_code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      rr_q        <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef PE_CONV_RR_ARBITER_STATS_EN
  logic [15:0]      grant_cnt_q [N_REQ];
  logic [15:0]      grant_cnt_d [N_REQ];
  logic [CNT_W-1:0] max_occ_q, max_occ_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) grant_cnt_d[i] = grant_cnt_q[i];
    if (fire) grant_cnt_d[grant] = grant_cnt_q[grant] + 16'd1;
    max_occ_d = (fifo_count > max_occ_q) ? fifo_count : max_occ_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= '0;
      max_occ_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      max_occ_q <= max_occ_d;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
    assign grant_count[gi*16 +: 16] = grant_cnt_q[gi];
  end
  assign max_occupancy = max_occ_q;
`endif

endmodule

// File: tb/tb_pe_conv_rr_arbiter.sv
module tb_pe_conv_rr_arbiter;

  localparam int N_REQ = 4;
  localparam int A_W   = 16;
  localparam int B_W   = 32;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic                 pe_in0_valid, pe_in0_ready, pe_in1_valid, pe_in1_ready;
  logic [A_W-1:0]       pe_in0_data;
  logic [B_W-1:0]       pe_in1_data;
  logic                 pe_out_valid, pe_out_ready;
  logic [A_W-1:0]       pe_out_data, rsp_data;
  logic                 drain_req, drain_done, error_valid;
  logic [15:0]          error_code;
`ifdef PE_CONV_RR_ARBITER_STATS_EN
  logic [N_REQ*16-1:0]  grant_count;
  logic [$clog2(DEPTH):0] max_occupancy;
  logic [15:0]          cnt1_0, cnt3_0;
`endif

  always #5 clk = ~clk;

  pe_conv_rr_arbiter #(.N_REQ(N_REQ), .A_W(A_W), .B_W(B_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .pe_in0_valid (pe_in0_valid),
    .pe_in0_ready (pe_in0_ready),
    .pe_in0_data  (pe_in0_data),
    .pe_in1_valid (pe_in1_valid),
    .pe_in1_ready (pe_in1_ready),
    .pe_in1_data  (pe_in1_data),
    .pe_out_valid (pe_out_valid),
    .pe_out_ready (pe_out_ready),
    .pe_out_data  (pe_out_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .error_valid  (error_valid),
    .error_code   (error_code)
`ifdef PE_CONV_RR_ARBITER_STATS_EN
    ,
    .grant_count  (grant_count),
    .max_occupancy(max_occupancy)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requesters: rem[i] transactions left; valid while any remain.
  int rem [N_REQ];
  always_comb for (int i = 0; i < N_REQ; i++) req_valid[i] = (rem[i] != 0);

  typedef struct {
    int          req;
    logic [15:0] res;
  } rsp_t;

  int          exp_g[$];
  rsp_t        exp_rsp[$];
  logic [15:0] pe_q[$];
  bit          pe_model_en = 1'b1;
  bit          fire_s, pop_s;
  int          fire_idx, e_idx, max_inflight, fire_cnt;
  logic [15:0] fire_res;
  rsp_t        r;

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor + scoreboard, sampled on the falling edge.
  initial begin
    fire_cnt = 0;
    max_inflight = 0;
    fire_idx = -1;
  end

  always @(negedge clk) begin
    fire_s = 1'b0;
    pop_s  = 1'b0;
    if (rst_n) begin
      fire_s = pe_in0_valid && pe_in1_valid && pe_in0_ready && pe_in1_ready;
      pop_s  = pe_out_valid && pe_out_ready;
      if (pop_s) begin
        if (exp_rsp.size() == 0) chk("rsp_pending", 32'(exp_rsp.size() != 0), 32'd1);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1) << r.req);
          chk("rsp_data", 32'(rsp_data), 32'(r.res));
        end
      end
      if (fire_s) begin
        fire_cnt++;
        fire_idx = onehot_idx(req_ready);
        fire_res = 16'(pe_in0_data + pe_in1_data[15:0]);
        if (exp_g.size() == 0) chk("grant_pending", 32'(exp_g.size() != 0), 32'd1);
        else begin
          e_idx = exp_g.pop_front();
          chk("grant_idx", 32'(fire_idx), 32'(e_idx));
          chk("req_ready", 32'(req_ready), 32'(1) << e_idx);
          chk("pe_in0_data", 32'(pe_in0_data), 32'(req_a[e_idx*A_W +: A_W]));
          chk("pe_in1_data", pe_in1_data, req_b[e_idx*B_W +: B_W]);
          exp_rsp.push_back('{e_idx, 16'(req_a[e_idx*A_W +: A_W] + req_b[e_idx*B_W +: 16])});
          if (exp_rsp.size() > max_inflight) max_inflight = exp_rsp.size();
        end
      end
    end
  end

  // Order-preserving PE model (one-cycle latency, a + low16(b)) and requester updates.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pe_q.delete();
      if (pe_model_en) begin
        pe_out_valid = 1'b0;
        pe_out_data  = '0;
      end
    end else begin
      if (fire_s && fire_idx >= 0 && rem[fire_idx] > 0) rem[fire_idx] = rem[fire_idx] - 1;
      if (pe_model_en) begin
        if (pop_s && pe_q.size() > 0) void'(pe_q.pop_front());
        if (fire_s) pe_q.push_back(fire_res);
        pe_out_valid = (pe_q.size() > 0);
        pe_out_data  = (pe_q.size() > 0) ? pe_q[0] : '0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_g.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pe_valid"}, {30'd0, pe_in0_valid, pe_in1_valid}, 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_pe_out_ready"}, 32'(pe_out_ready), 32'd0);
    chk({tag, "_drain_done"}, 32'(drain_done), 32'd0);
    chk({tag, "_error"}, {15'd0, error_valid, error_code}, 32'd0);
    chk({tag, "_data"}, {pe_in0_data, rsp_data}, 32'd0);
    chk({tag, "_in1_data"}, pe_in1_data, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  int f0;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) rem[i] = 0;
    req_a = '0;
    req_b = '0;
    rsp_ready = '0;
    drain_req = 1'b0;
    pe_in0_ready = 1'b1;
    pe_in1_ready = 1'b1;
    pe_out_valid = 1'b0;
    pe_out_data = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    cyc();
    rst_n = 1'b1;

    // Round-robin across all four with the real PE.
    req_a = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0003};
    req_b = {32'h0000_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0005};
    rsp_ready = '1;
    exp_g = '{0, 1, 2, 3};
    for (int i = 0; i < N_REQ; i++) rem[i] = 1;
    wait_idle("rr_done", 40);

    // Fairness between requesters 1 and 3.
`ifdef PE_CONV_RR_ARBITER_STATS_EN
    cnt1_0 = grant_count[16 +: 16];
    cnt3_0 = grant_count[48 +: 16];
`endif
    req_a[16 +: 16] = 16'h1234;
    req_b[32 +: 32] = 32'h0001_0001;
    req_a[48 +: 16] = 16'hFFFE;
    req_b[96 +: 32] = 32'h0000_0005;
    exp_g = '{1, 3, 1, 3, 1, 3};
    rem[1] = 3;
    rem[3] = 3;
    wait_idle("fair_done", 40);
`ifdef PE_CONV_RR_ARBITER_STATS_EN
    @(negedge clk);
    chk("fair_cnt1", 32'(grant_count[16 +: 16] - cnt1_0), 32'd3);
    chk("fair_cnt3", 32'(grant_count[48 +: 16] - cnt3_0), 32'd3);
`endif

    // Backpressure: FIFO fills at DEPTH, then one pop allows one new fire.
    rsp_ready = '0;
    max_inflight = 0;
    f0 = fire_cnt;
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < N_REQ; i++) rem[i] = 2;
    repeat (8) @(negedge clk);
    chk("bp_fires", 32'(fire_cnt - f0), 32'd4);
    chk("bp_full_valid", 32'(pe_in0_valid), 32'd0);
    cyc();
    rsp_ready = '1;
    @(negedge clk);
    chk("bp_pop_ready", 32'(pe_out_ready), 32'd1);
    chk("bp_no_push_full", 32'(pe_in0_valid), 32'd0);
    @(negedge clk);
    chk("bp_refire", 32'(pe_in0_valid), 32'd1);
    wait_idle("bp_done", 60);
    chk("bp_max_inflight", 32'(max_inflight), 32'd4);
`ifdef PE_CONV_RR_ARBITER_STATS_EN
    chk("bp_max_occ", 32'(max_occupancy), 32'd4);
`endif

    // Drain with three in flight; resume from saved pointer (3).
    rsp_ready = '0;
    f0 = fire_cnt;
    exp_g = '{0, 1, 2};
    rem[0] = 1; rem[1] = 1; rem[2] = 1;
    repeat (5) @(negedge clk);
    chk("dr_fires", 32'(fire_cnt - f0), 32'd3);
    cyc();
    drain_req = 1'b1;
    rem[0] = 1;
    rem[3] = 1;
    @(negedge clk);
    chk("dr_first_cycle", 32'(pe_in0_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("dr_hold", 32'(fire_cnt - f0), 32'd3);
    chk("dr_not_done", 32'(drain_done), 32'd0);
    cyc();
    rsp_ready = '1;
    repeat (4) @(negedge clk);
    chk("dr_done_lag", 32'(drain_done), 32'd0);
    @(negedge clk);
    chk("dr_done", 32'(drain_done), 32'd1);
    chk("dr_no_issue", 32'(pe_in0_valid), 32'd0);
    cyc();
    drain_req = 1'b0;
    exp_g = '{3, 0};
    wait_idle("dr_resume", 40);

    // Orphan result with empty FIFO.
    cyc();
    pe_model_en = 1'b0;
    pe_out_valid = 1'b1;
    pe_out_data = 16'h55AA;
    rsp_ready = '1;
    @(negedge clk);
    chk("orph_ready", 32'(pe_out_ready), 32'd0);
    chk("orph_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("orph_not_yet", 32'(error_valid), 32'd0);
    @(negedge clk);
    chk("orph_err", 32'(error_valid), 32'd1);
    chk("orph_code", 32'(error_code), 32'h0001);
    repeat (3) @(negedge clk);
    chk("orph_sticky", {15'd0, error_valid, error_code}, 32'h0001_0001);
    cyc();
    pe_out_valid = 1'b0;
    pe_out_data = '0;
    pe_model_en = 1'b1;

    // Reset with two in flight, then resume with rr pointer back at 0.
    rsp_ready = '0;
    exp_g = '{1, 0};
    rem[0] = 1;
    rem[1] = 1;
    repeat (4) @(negedge clk);
    chk("rs_inflight", 32'(exp_rsp.size()), 32'd2);
    cyc();
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) rem[i] = 0;
    exp_g.delete();
    exp_rsp.delete();
    @(negedge clk);
    chk_quiet("rs_reset");
    cyc();
    cyc();
    rst_n = 1'b1;
    rsp_ready = '1;
    exp_g = '{0, 3};
    rem[0] = 1;
    rem[3] = 1;
    wait_idle("rs_resume", 40);
    @(negedge clk);
    chk("rs_no_error", 32'(error_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
